// File: rtl/xps2_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: register map, STATUS
// layout, deframer state encoding and parity helper.
// Optional build macro: PS2_BRK_FILTER_EN (adds the break-code constant).
package xps2_rx_pkg;

    localparam int unsigned BYTE_W = 8;

    // Register map (one address bit)
    localparam logic ADDR_DATA   = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

    // STATUS flag bit positions; FIFO count starts right above OVF
    localparam int unsigned STAT_PERR_BIT = 1;
    localparam int unsigned STAT_FERR_BIT = 2;
    localparam int unsigned STAT_OVF_BIT  = 3;

`ifdef PS2_BRK_FILTER_EN
    localparam logic [BYTE_W-1:0] BRK_CODE = 8'hF0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    // Low nibble of the STATUS word (MSB first: OVF, FERR, PERR, !empty)
    typedef struct packed {
        logic ovf;
        logic ferr;
        logic perr;
        logic nempty;
    } stat_flags_t;

    // Odd parity over data+parity bit: an even number of ones is an error
    function automatic logic parity_bad(input logic [BYTE_W-1:0] b, input logic p);
        return ~(^{b, p});
    endfunction

endpackage

// File: rtl/xps2_fifo.sv
// Synchronous scancode FIFO, depth 2**ADDR_W, first-word-fall-through head.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module xps2_fifo
    import xps2_rx_pkg::*;
#(
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [BYTE_W-1:0] wdata,
    output logic [BYTE_W-1:0] head_c,
    output logic              full_c,
    output logic              empty_c,
    output logic [ADDR_W:0]   count
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic              do_push_c;
    logic              do_pop_c;

    // Occupancy flags and accepted push/pop qualifiers
    always_comb begin
        empty_c   = (count == '0);
        full_c    = (count == CNT_W'(DEPTH));
        do_pop_c  = pop & ~empty_c;
        do_push_c = push & (~full_c | do_pop_c);
        head_c    = mem[rd_ptr_q];
    end

    // Pointers and occupancy count
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
        end else begin
            if (do_push_c) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (do_pop_c)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            case ({do_push_c, do_pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array, written on accepted push
    always_ff @(posedge clk) begin
        if (do_push_c) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/xps2_rx.sv
// PS/2 keyboard receiver: line synchronizer, 11-bit frame deframer with
// timeout, sticky error flags, scancode FIFO and DATA/STATUS bus registers.
// Build macro PS2_BRK_FILTER_EN: swallow 0xF0 break codes and the key code
// that follows them; undefined, every good frame is pushed.
module xps2_rx
    import xps2_rx_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned FIFO_ADDR_W = 2,
    parameter int unsigned TIMEOUT_CYC = 2000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    input  logic              sel,
    input  logic              we,
    input  logic              addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rx_irq
);

    localparam int unsigned CNT_W  = FIFO_ADDR_W + 1;
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned STAT_W = CNT_W + 4;

    logic              clk_m, clk_s, clk_q;
    logic              dat_m, dat_s;
    logic              fall_c;

    rx_state_t         state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic [TO_W-1:0]   to_cnt_q;
    logic              to_expired_c;
    logic              frame_ok_c, frame_err_c;

    logic              push_c, pop_c;
    logic              data_rd_c, stat_rd_c, stat_wr_c;
    logic              ovf_q, ferr_q, perr_q;
    logic              ovf_set_c, perr_set_c;
    stat_flags_t       flags_c;
    logic [STAT_W-1:0] status_c;
    logic              unused_c;

    logic [BYTE_W-1:0] fifo_head;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    // Two-FF synchronizers plus clock history for falling-edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_m <= 1'b1;
            clk_s <= 1'b1;
            clk_q <= 1'b1;
            dat_m <= 1'b1;
            dat_s <= 1'b1;
        end else begin
            clk_m <= ps2_clk;
            clk_s <= clk_m;
            clk_q <= clk_s;
            dat_m <= ps2_data;
            dat_s <= dat_m;
        end
    end

    assign fall_c       = clk_q & ~clk_s;
    assign to_expired_c = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    // Deframer state register and frame datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
        end
    end

    // Deframer next-state: start, 8 data bits LSB first, parity, stop
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        frame_ok_c  = 1'b0;
        frame_err_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fall_c && !dat_s) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (fall_c) begin
                    shift_d   = {dat_s, shift_q[BYTE_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PAR;
                end else if (to_expired_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAR: begin
                if (fall_c) begin
                    par_d   = dat_s;
                    state_d = ST_STOP;
                end else if (to_expired_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STOP: begin
                if (fall_c) begin
                    frame_ok_c  = dat_s;
                    frame_err_c = ~dat_s;
                    state_d     = ST_IDLE;
                end else if (to_expired_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Inactivity counter: cleared in IDLE and on every PS/2 clock fall
    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt_q <= '0;
        end else if (state_q == ST_IDLE || fall_c) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

`ifdef PS2_BRK_FILTER_EN
    logic brk_armed_q;

    // Break-code filter: drop 0xF0 and the next good byte
    always_ff @(posedge clk) begin
        if (!rst) begin
            brk_armed_q <= 1'b0;
        end else if (frame_err_c) begin
            brk_armed_q <= 1'b0;
        end else if (frame_ok_c) begin
            brk_armed_q <= ~brk_armed_q & (shift_q == BRK_CODE);
        end
    end

    assign push_c = frame_ok_c & ~brk_armed_q & (shift_q != BRK_CODE);
`else
    assign push_c = frame_ok_c;
`endif

    // Bus decode and flag set conditions
    always_comb begin
        data_rd_c  = sel & ~we & (addr == ADDR_DATA);
        stat_rd_c  = sel & ~we & (addr == ADDR_STATUS);
        stat_wr_c  = sel &  we & (addr == ADDR_STATUS);
        pop_c      = data_rd_c & ~fifo_empty;
        ovf_set_c  = push_c & fifo_full & ~pop_c;
        perr_set_c = frame_ok_c & parity_bad(shift_q, par_q);
        flags_c    = '{ovf: ovf_q, ferr: ferr_q, perr: perr_q, nempty: ~fifo_empty};
        status_c   = {fifo_count, flags_c};
        unused_c   = ^{data_in[DATA_W-1:STAT_OVF_BIT+1], data_in[0]};
    end

    // Sticky error flags: set wins over write-1-to-clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q  <= 1'b0;
            ferr_q <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_set_c   | (ovf_q  & ~(stat_wr_c & data_in[STAT_OVF_BIT]));
            ferr_q <= frame_err_c | (ferr_q & ~(stat_wr_c & data_in[STAT_FERR_BIT]));
            perr_q <= perr_set_c  | (perr_q & ~(stat_wr_c & data_in[STAT_PERR_BIT]));
        end
    end

    // Registered read data and interrupt
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_out <= '0;
            rx_irq   <= 1'b0;
        end else begin
            rx_irq <= ~fifo_empty;
            if (data_rd_c) begin
                data_out <= fifo_empty ? '0 : DATA_W'(fifo_head);
            end else if (stat_rd_c) begin
                data_out <= DATA_W'(status_c);
            end
        end
    end

    xps2_fifo #(
        .ADDR_W (FIFO_ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_c),
        .pop     (pop_c),
        .wdata   (shift_q),
        .head_c  (fifo_head),
        .full_c  (fifo_full),
        .empty_c (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_xps2_rx.sv
// Bench for xps2_rx: directed frames with literal expectations, then random
// frames checked against a queue-based model of the receiver.
module tb_xps2_rx;

    localparam int HALF = 60;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps2_clk;
    logic        ps2_data;
    logic        sel;
    logic        we;
    logic        addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        rx_irq;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    logic       m_ovf, m_ferr, m_perr, m_armed;

    xps2_rx dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .sel      (sel),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .rx_irq   (rx_irq)
    );

    always #5 clk = ~clk;

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive nbits of a frame; data changes while ps2_clk is high
    task automatic send(input logic [7:0] b, input logic par, input logic stop, input int nbits);
        logic [10:0] fr;
        fr = {stop, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = fr[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] b);
        send(b, ~^b, 1'b1, 11);
    endtask

    task automatic bus_read(input logic a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        sel = 1'b0;
        d = data_out;
    endtask

    task automatic bus_write(input logic a, input logic [31:0] v);
        @(negedge clk);
        sel = 1'b1; we = 1'b1; addr = a; data_in = v;
        @(negedge clk);
        sel = 1'b0; we = 1'b0; data_in = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        mq.delete();
        m_ovf = 0; m_ferr = 0; m_perr = 0; m_armed = 0;
    endtask

    // Receiver behaviour at frame granularity
    task automatic model_frame(input logic [7:0] b, input logic par, input logic stop);
        bit drop;
        if (!stop) begin
            m_ferr  = 1'b1;
            m_armed = 1'b0;
        end else begin
            if ($countones({b, par}) % 2 == 0) m_perr = 1'b1;
            drop = 0;
`ifdef PS2_BRK_FILTER_EN
            if (m_armed) begin
                drop = 1; m_armed = 1'b0;
            end else if (b == 8'hF0) begin
                drop = 1; m_armed = 1'b1;
            end
`endif
            if (!drop) begin
                if (mq.size() == 4) m_ovf = 1'b1;
                else mq.push_back(b);
            end
        end
    endtask

    task automatic model_data(input string tag);
        logic [31:0] d, e;
        bus_read(1'b0, d);
        e = (mq.size() != 0) ? {24'h0, mq.pop_front()} : 32'h0;
        check(tag, d, e);
    endtask

    task automatic model_status(input string tag);
        logic [31:0] d, e;
        logic [2:0]  c;
        bus_read(1'b1, d);
        c = 3'(mq.size());
        e = {25'h0, c, m_ovf, m_ferr, m_perr, (mq.size() != 0)};
        check(tag, d, e);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  rb;
        logic        rp, rs;
        logic [3:0]  wv;

        rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        sel = 1'b0; we = 1'b0; addr = 1'b0; data_in = '0;
        repeat (5) @(negedge clk);
        check("rst_data_out", data_out, 32'h0);
        check("rst_irq", {31'h0, rx_irq}, 32'h0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        bus_read(1'b1, d);
        check("rst_status", d, 32'h0);

        // 0x79 with even total ones: parity error, byte still delivered
        send(8'h79, 1'b1, 1'b1, 11);
        check("irq_after_79", {31'h0, rx_irq}, 32'h1);
        bus_read(1'b1, d);
        check("stat_79", d, 32'h13);
        bus_read(1'b0, d);
        check("data_79", d, 32'h79);
        repeat (2) @(negedge clk);
        check("irq_after_read", {31'h0, rx_irq}, 32'h0);

        // 0x69 good parity: PERR stays sticky until cleared
        send(8'h69, 1'b1, 1'b1, 11);
        bus_read(1'b1, d);
        check("stat_69", d, 32'h13);
        bus_read(1'b0, d);
        check("data_69", d, 32'h69);
        bus_write(1'b1, 32'h2);
        bus_read(1'b1, d);
        check("stat_perr_clr", d, 32'h0);

        // Bad stop bit: FERR, nothing queued
        send(8'h74, 1'b1, 1'b0, 11);
        check("irq_ferr", {31'h0, rx_irq}, 32'h0);
        bus_read(1'b1, d);
        check("stat_ferr", d, 32'h04);
        bus_write(1'b1, 32'h4);

        // Overflow: fifth frame dropped, first four intact
        send_good(8'h79); send_good(8'h69); send_good(8'h74);
        send_good(8'h5A); send_good(8'h7B);
        bus_read(1'b1, d);
        check("stat_ovf", d, 32'h49);
        bus_read(1'b0, d); check("ovf_rd0", d, 32'h79);
        bus_read(1'b0, d); check("ovf_rd1", d, 32'h69);
        bus_read(1'b0, d); check("ovf_rd2", d, 32'h74);
        bus_read(1'b0, d); check("ovf_rd3", d, 32'h5A);
        bus_read(1'b0, d); check("empty_rd", d, 32'h0);
        bus_read(1'b1, d);
        check("stat_ovf_empty", d, 32'h08);
        bus_write(1'b1, 32'h8);

        // Partial frame abandoned by inactivity timeout
        send(8'h0F, 1'b0, 1'b1, 5);
        repeat (2500) @(negedge clk);
        send_good(8'h5A);
        bus_read(1'b1, d);
        check("stat_timeout", d, 32'h11);
        bus_read(1'b0, d);
        check("data_timeout", d, 32'h5A);

        // Partial frame abandoned by reset
        send(8'h0F, 1'b0, 1'b1, 5);
        do_reset();
        send_good(8'h5A);
        bus_read(1'b1, d);
        check("stat_rstmid", d, 32'h11);
        bus_read(1'b0, d);
        check("data_rstmid", d, 32'h5A);

        // Break code followed by key code
        send_good(8'hF0);
        send_good(8'h74);
        bus_read(1'b1, d);
`ifdef PS2_BRK_FILTER_EN
        check("stat_brk", d, 32'h00);
`else
        check("stat_brk", d, 32'h21);
        bus_read(1'b0, d); check("brk_rd0", d, 32'hF0);
        bus_read(1'b0, d); check("brk_rd1", d, 32'h74);
`endif

        // Random frames against the model
        do_reset();
        for (int n = 0; n < 16; n++) begin
            rb = 8'($urandom);
            rp = (~^rb) ^ ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 7) != 0);
            send(rb, rp, rs, 11);
            model_frame(rb, rp, rs);
            if ($urandom_range(0, 1) == 1) model_data("rnd_data");
            if ($urandom_range(0, 3) == 0) model_status("rnd_status");
            if ($urandom_range(0, 4) == 0) begin
                wv = 4'($urandom);
                bus_write(1'b1, {28'h0, wv});
                if (wv[3]) m_ovf  = 1'b0;
                if (wv[2]) m_ferr = 1'b0;
                if (wv[1]) m_perr = 1'b0;
            end
        end
        model_status("rnd_final_status");
        for (int k = 0; k < 5; k++) model_data("rnd_drain");
        model_status("rnd_drained_status");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
